// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI shift engine: lane modes, FSM states,
// per-mode SCLK-per-byte constants and the lane packing/unpacking helpers.
package qspi_pkg;

    typedef enum logic [1:0] {
        LANE_SINGLE = 2'b00,
        LANE_DUAL   = 2'b01,
        LANE_QUAD   = 2'b10
    } lane_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_SHIFT,
        ST_PUSH,
        ST_HOLD
    } state_e;

    localparam int unsigned SCLK_PER_BYTE_SINGLE = 8;
    localparam int unsigned SCLK_PER_BYTE_DUAL   = 4;
    localparam int unsigned SCLK_PER_BYTE_QUAD   = 2;

    // Encoding 2'b11 is reserved and runs as single-lane.
    function automatic lane_mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'b01:   return LANE_DUAL;
            2'b10:   return LANE_QUAD;
            default: return LANE_SINGLE;
        endcase
    endfunction

    // Index of the last bit group in a byte (SCLK cycles per byte minus one).
    function automatic logic [2:0] last_group(input lane_mode_e m);
        case (m)
            LANE_DUAL: return 3'(SCLK_PER_BYTE_DUAL - 1);
            LANE_QUAD: return 3'(SCLK_PER_BYTE_QUAD - 1);
            default:   return 3'(SCLK_PER_BYTE_SINGLE - 1);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input lane_mode_e m);
        case (m)
            LANE_DUAL: return 4'b0011;
            LANE_QUAD: return 4'b1111;
            default:   return 4'b0001;
        endcase
    endfunction

    // Top bits of the shift register mapped onto the lanes, MSB on the highest lane.
    function automatic logic [3:0] tx_group(input lane_mode_e m, input logic [7:0] b);
        case (m)
            LANE_DUAL: return {2'b00, b[7:6]};
            LANE_QUAD: return b[7:4];
            default:   return {3'b000, b[7]};
        endcase
    endfunction

    function automatic logic [7:0] tx_advance(input lane_mode_e m, input logic [7:0] b);
        case (m)
            LANE_DUAL: return {b[5:0], 2'b00};
            LANE_QUAD: return {b[3:0], 4'b0000};
            default:   return {b[6:0], 1'b0};
        endcase
    endfunction

    // Single mode receives on io[1]; multi-lane modes receive on the low lanes.
    function automatic logic [7:0] rx_merge(input lane_mode_e m, input logic [7:0] sh,
                                            input logic [3:0] io);
        case (m)
            LANE_DUAL: return {sh[5:0], io[1:0]};
            LANE_QUAD: return {sh[3:0], io};
            default:   return {sh[6:0], io[1]};
        endcase
    endfunction

endpackage

// File: rtl/qspi_shift_engine_if.sv
// FIFO-side bus of the QSPI shift engine. master = engine, slave = FIFO pair.
interface qspi_shift_engine_if #(parameter int unsigned DWID = 8);

    logic [DWID-1:0] tx_rdata;
    logic            tx_empty;
    logic            tx_ren;
    logic [DWID-1:0] rx_wdata;
    logic            rx_wen;
    logic            rx_full;

    modport master (
        input  tx_rdata, tx_empty, rx_full,
        output tx_ren, rx_wdata, rx_wen
    );

    modport slave (
        output tx_rdata, tx_empty, rx_full,
        input  tx_ren, rx_wdata, rx_wen
    );

endinterface

// File: rtl/qspi_clkgen.sv
// SCLK half-period generator. Counts div..0 while run is high; on the zero
// count it reloads and, when toggle_en is set, toggles sclk and flags the
// corresponding rise/fall. Outside run (or on clr) sclk is forced low.
module qspi_clkgen #(
    parameter int unsigned DIVWID = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              toggle_en,
    input  logic              clr,
    input  logic [DIVWID-1:0] div,
    output logic              sclk,
    output logic              tick,
    output logic              rise,
    output logic              fall
);

    logic [DIVWID-1:0] cnt;

    assign tick = run && !clr && (cnt == '0);
    assign rise = tick && toggle_en && !sclk;
    assign fall = tick && toggle_en && sclk;

    // Half-period down-counter and sclk toggle.
    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt  <= div;
            sclk <= 1'b0;
        end else if (cnt == '0) begin
            cnt <= div;
            if (toggle_en)
                sclk <= ~sclk;
        end else begin
            cnt <= cnt - DIVWID'(1);
        end
    end

endmodule

// File: rtl/qspi_shift_engine.sv
// QSPI shift engine: pops TX FIFO bytes, shifts them out on 1/2/4 lanes in
// SPI mode 0, packs sampled lanes into bytes for the RX FIFO.
// Optional feature macro: QSPI_ABORT_EN (adds the abort input).
module qspi_shift_engine
    import qspi_pkg::*;
#(
    parameter int unsigned DWID   = 8,
    parameter int unsigned LENWID = 16,
    parameter int unsigned DIVWID = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef QSPI_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [LENWID-1:0] xfer_len,
    input  logic [1:0]        lane_mode,
    input  logic              tx_en,
    input  logic              rx_en,
    input  logic [DIVWID-1:0] clk_div,
    qspi_shift_engine_if.master fifo,
    output logic              sclk,
    output logic              cs_n,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    input  logic [3:0]        io_in,
    output logic              busy,
    output logic              done
);

    state_e            state;
    lane_mode_e        mode_q;
    logic              tx_en_q;
    logic              rx_en_q;
    logic [LENWID-1:0] len_q;
    logic [DIVWID-1:0] div_q;
    logic [LENWID-1:0] byte_cnt;
    logic [2:0]        grp_cnt;
    logic [DWID-1:0]   tx_sh;
    logic [DWID-1:0]   rx_sh;
    logic [DWID-1:0]   tx_next;
    logic              tx_ren_q;
    logic              rx_wen_q;
    logic [DWID-1:0]   rx_wdata_q;

    logic              gen_run;
    logic              gen_toggle;
    logic [DIVWID-1:0] div_src;
    logic              tick;
    logic              rise;
    logic              fall;
    logic              abort_hit;

`ifdef QSPI_ABORT_EN
    // HOLD is already the abort target, so a held abort cannot stall it.
    assign abort_hit = abort && (state != ST_IDLE) && (state != ST_HOLD);
`else
    assign abort_hit = 1'b0;
`endif

    assign fifo.tx_ren   = tx_ren_q;
    assign fifo.rx_wen   = rx_wen_q;
    assign fifo.rx_wdata = rx_wdata_q;

    assign gen_run    = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign gen_toggle = (state == ST_SHIFT);
    // In IDLE the counter preloads straight from clk_div so SETUP starts with the new value.
    assign div_src    = (state == ST_IDLE) ? clk_div : div_q;
    assign tx_next    = tx_advance(mode_q, tx_sh);

    qspi_clkgen #(
        .DIVWID (DIVWID)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .run       (gen_run),
        .toggle_en (gen_toggle),
        .clr       (abort_hit),
        .div       (div_src),
        .sclk      (sclk),
        .tick      (tick),
        .rise      (rise),
        .fall      (fall)
    );

    // Transfer FSM with registered pad and FIFO strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= LANE_SINGLE;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            len_q      <= '0;
            div_q      <= '0;
            byte_cnt   <= '0;
            grp_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            tx_ren_q   <= 1'b0;
            rx_wen_q   <= 1'b0;
            rx_wdata_q <= '0;
            cs_n       <= 1'b1;
            io_out     <= '0;
            io_oe      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_wen_q <= 1'b0;
            if (abort_hit) begin
                state    <= ST_HOLD;
                tx_ren_q <= 1'b0;
                io_out   <= '0;
                io_oe    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            mode_q   <= norm_mode(lane_mode);
                            tx_en_q  <= tx_en;
                            // Multi-lane with TX enabled has no free lanes to receive on.
                            rx_en_q  <= rx_en && (!tx_en || norm_mode(lane_mode) == LANE_SINGLE);
                            len_q    <= xfer_len;
                            div_q    <= clk_div;
                            byte_cnt <= '0;
                            io_out   <= '0;
                            io_oe    <= tx_en ? lane_mask(norm_mode(lane_mode)) : 4'b0000;
                            busy     <= 1'b1;
                            cs_n     <= 1'b0;
                            state    <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (tick)
                            state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        // Pop is a registered strobe; the byte is captured while it is high.
                        if (tx_ren_q) begin
                            tx_ren_q <= 1'b0;
                            tx_sh    <= fifo.tx_rdata;
                            io_out   <= tx_group(mode_q, fifo.tx_rdata);
                            rx_sh    <= '0;
                            grp_cnt  <= last_group(mode_q);
                            state    <= ST_SHIFT;
                        end else if (!tx_en_q) begin
                            tx_sh   <= '0;
                            io_out  <= '0;
                            rx_sh   <= '0;
                            grp_cnt <= last_group(mode_q);
                            state   <= ST_SHIFT;
                        end else if (!fifo.tx_empty) begin
                            tx_ren_q <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (rise) begin
                            rx_sh <= rx_merge(mode_q, rx_sh, io_in);
                        end else if (fall) begin
                            if (grp_cnt == 3'd0) begin
                                state <= ST_PUSH;
                            end else begin
                                grp_cnt <= grp_cnt - 3'd1;
                                tx_sh   <= tx_next;
                                io_out  <= tx_en_q ? tx_group(mode_q, tx_next) : 4'b0000;
                            end
                        end
                    end
                    ST_PUSH: begin
                        if (!(rx_en_q && fifo.rx_full)) begin
                            if (rx_en_q) begin
                                rx_wen_q   <= 1'b1;
                                rx_wdata_q <= rx_sh;
                            end
                            if (byte_cnt == len_q) begin
                                state <= ST_HOLD;
                            end else begin
                                byte_cnt <= byte_cnt + LENWID'(1);
                                state    <= ST_LOAD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (tick) begin
                            cs_n   <= 1'b1;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            io_out <= '0;
                            io_oe  <= '0;
                            state  <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
